// File: rtl/oled_cmd_queue.sv
// ---------------------------------------------------------------------------
// oled_cmd_queue
// Buffers display commands from the game logic and hands them one at a time
// to the OLED driver.  A DEPTH-entry FIFO holds {type, charval, row, col, bmp}.
// A small sequencer pops the head while the driver is idle, pulses exactly one
// command strobe, then waits for the driver to go busy and return to idle.
// If the driver never goes busy, the command is treated as done after
// ACK_TIMEOUT cycles.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid, cmd_type,        producer command offer and its operands
//   cmd_charval, cmd_row,       (cmd_type: 0=char, 1=bmp, 2=clear,
//   cmd_col, cmd_bmp            3=reserved, which is silently dropped)
//   cmd_ready                   queue not full
//   drv_ready                   driver idle
//   showchar, showbmp, clear    registered one-cycle strobes to the driver
//   charval, char_row,          operands of the command last popped
//   char_col, bmp
//   count                       number of queued entries
//   overflow                    sticky: a command was offered while full
// ---------------------------------------------------------------------------
module oled_cmd_queue #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_type,
    input  logic [7:0]               cmd_charval,
    input  logic [1:0]               cmd_row,
    input  logic [3:0]               cmd_col,
    input  logic [1:0]               cmd_bmp,
    output logic                     cmd_ready,
    input  logic                     drv_ready,
    output logic                     showchar,
    output logic                     showbmp,
    output logic                     clear,
    output logic [7:0]               charval,
    output logic [1:0]               char_row,
    output logic [3:0]               char_col,
    output logic [1:0]               bmp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam int EW = 18;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [EW-1:0] mem_r [DEPTH];
    logic [CW-1:0] wr_ptr_r;
    logic [CW-1:0] rd_ptr_r;
    logic [CW-1:0] count_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [1:0]    issue_type_r;

    logic          showchar_r;
    logic          showbmp_r;
    logic          clear_r;
    logic [7:0]    charval_r;
    logic [1:0]    char_row_r;
    logic [3:0]    char_col_r;
    logic [1:0]    bmp_r;
    logic          overflow_r;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count_s   = wr_ptr_r - rd_ptr_r;
    assign full_s    = (count_s == CW'(DEPTH));
    assign empty_s   = (count_s == CW'(0));
    assign cmd_ready = ~full_s;

    // Reserved commands are consumed (handshake completes) but not stored.
    assign push_s = cmd_valid & ~full_s & (cmd_type != 2'd3);
    assign pop_s  = (state_r == ST_IDLE) & ~empty_s & drv_ready;
    assign head_s = mem_r[rd_ptr_r[AW-1:0]];

    // FIFO storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {cmd_type, cmd_charval, cmd_row, cmd_col, cmd_bmp};
        end
    end

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= CW'(0);
            rd_ptr_r   <= CW'(0);
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + CW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + CW'(1);
            end
            if (cmd_valid && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Sequencer next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!drv_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (timer_r == TW'(ACK_TIMEOUT - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (drv_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and busy-wait timer; the timer counts edges spent in
    // WAIT_BUSY so the stay there lasts exactly ACK_TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= TW'(0);
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_WAIT_BUSY) begin
                timer_r <= timer_r + TW'(1);
            end else begin
                timer_r <= TW'(0);
            end
        end
    end

    // Operand registers load on pop and then hold while the driver works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_type_r <= 2'd0;
            charval_r    <= 8'd0;
            char_row_r   <= 2'd0;
            char_col_r   <= 4'd0;
            bmp_r        <= 2'd0;
        end else if (pop_s) begin
            {issue_type_r, charval_r, char_row_r, char_col_r, bmp_r} <= head_s;
        end
    end

    // Strobes are registered from the ISSUE state, so they are mutually
    // exclusive and last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            showchar_r <= 1'b0;
            showbmp_r  <= 1'b0;
            clear_r    <= 1'b0;
        end else begin
            showchar_r <= (state_r == ST_ISSUE) && (issue_type_r == 2'd0);
            showbmp_r  <= (state_r == ST_ISSUE) && (issue_type_r == 2'd1);
            clear_r    <= (state_r == ST_ISSUE) && (issue_type_r == 2'd2);
        end
    end

    assign showchar = showchar_r;
    assign showbmp  = showbmp_r;
    assign clear    = clear_r;
    assign charval  = charval_r;
    assign char_row = char_row_r;
    assign char_col = char_col_r;
    assign bmp      = bmp_r;
    assign count    = count_s;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_oled_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_oled_cmd_queue
// Directed, table-driven bench for oled_cmd_queue.  Inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_oled_cmd_queue;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic [7:0] cmd_charval;
    logic [1:0] cmd_row;
    logic [3:0] cmd_col;
    logic [1:0] cmd_bmp;
    logic       cmd_ready;
    logic       drv_ready;
    logic       showchar;
    logic       showbmp;
    logic       clear;
    logic [7:0] charval;
    logic [1:0] char_row;
    logic [3:0] char_col;
    logic [1:0] bmp;
    logic [3:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe log filled by run_driver
    int         log_kind[$];
    logic [7:0] log_ch[$];
    logic [1:0] log_row[$];
    logic [3:0] log_col[$];
    logic [1:0] log_bmp[$];
    int         log_cyc[$];

    typedef struct {
        logic       valid;
        logic [1:0] typ;
        logic [7:0] ch;
        logic [1:0] row;
        logic [3:0] col;
        logic [1:0] bm;
        logic       drv;
        logic [3:0] exp_count;
        logic       exp_ready;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[11];

    oled_cmd_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_charval(cmd_charval),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_bmp    (cmd_bmp),
        .cmd_ready  (cmd_ready),
        .drv_ready  (drv_ready),
        .showchar   (showchar),
        .showbmp    (showbmp),
        .clear      (clear),
        .charval    (charval),
        .char_row   (char_row),
        .char_col   (char_col),
        .bmp        (bmp),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] t, input logic [7:0] ch,
                           input logic [1:0] r, input logic [3:0] c, input logic [1:0] b);
        cmd_valid   = v;
        cmd_type    = t;
        cmd_charval = ch;
        cmd_row     = r;
        cmd_col     = c;
        cmd_bmp     = b;
    endtask

    task automatic push(input logic [1:0] t, input logic [7:0] ch,
                        input logic [1:0] r, input logic [3:0] c, input logic [1:0] b);
        set_cmd(1'b1, t, ch, r, c, b);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},    32'(count),     32'd0);
        check({tag, "_ready"},    32'(cmd_ready), 32'd1);
        check({tag, "_overflow"}, 32'(overflow),  32'd0);
        check({tag, "_showchar"}, 32'(showchar),  32'd0);
        check({tag, "_showbmp"},  32'(showbmp),   32'd0);
        check({tag, "_clear"},    32'(clear),     32'd0);
        check({tag, "_charval"},  32'(charval),   32'd0);
        check({tag, "_row"},      32'(char_row),  32'd0);
        check({tag, "_col"},      32'(char_col),  32'd0);
        check({tag, "_bmp"},      32'(bmp),       32'd0);
    endtask

    // Driver model: on each strobe it drops drv_ready for busy_len cycles
    // (busy_len = 0 means it never goes busy).  Logs every strobe.
    task automatic run_driver(input int cycles, input int busy_len);
        int busy_cnt;
        int nstb;
        busy_cnt = 0;
        log_kind.delete();
        log_ch.delete();
        log_row.delete();
        log_col.delete();
        log_bmp.delete();
        log_cyc.delete();
        for (int i = 0; i < cycles; i++) begin
            tick();
            nstb = int'(showchar) + int'(showbmp) + int'(clear);
            check("strobe_onehot", 32'(nstb <= 1), 32'd1);
            if (nstb != 0) begin
                log_kind.push_back(showchar ? 0 : (showbmp ? 1 : 2));
                log_ch.push_back(charval);
                log_row.push_back(char_row);
                log_col.push_back(char_col);
                log_bmp.push_back(bmp);
                log_cyc.push_back(i);
                if (busy_len > 0) begin
                    drv_ready = 1'b0;
                    busy_cnt  = busy_len;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    drv_ready = 1'b1;
                end
            end
        end
        drv_ready = 1'b1;
    endtask

    initial begin
        // Fill/overflow table: reserved cmd, then 9 pushes with driver busy
        vecs[0]  = '{1'b1, 2'd3, 8'hEE, 2'd0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 8'h50, 2'd0, 4'd0, 2'd0, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 8'h51, 2'd1, 4'd1, 2'd1, 1'b0, 4'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'd0, 8'h52, 2'd2, 4'd2, 2'd2, 1'b0, 4'd3, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 8'h53, 2'd3, 4'd3, 2'd3, 1'b0, 4'd4, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 8'h54, 2'd0, 4'd4, 2'd0, 1'b0, 4'd5, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 8'h55, 2'd1, 4'd5, 2'd1, 1'b0, 4'd6, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 8'h56, 2'd2, 4'd6, 2'd2, 1'b0, 4'd7, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 8'h57, 2'd3, 4'd7, 2'd3, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 8'h58, 2'd0, 4'd8, 2'd0, 1'b0, 4'd8, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 2'd0, 4'd0, 2'd0, 1'b0, 4'd8, 1'b0, 1'b1};

        rst_n     = 1'b0;
        drv_ready = 1'b1;
        set_cmd(1'b0, 2'd0, 8'd0, 2'd0, 4'd0, 2'd0);
        #1;
        check_reset_outputs("por");
        tick();
        rst_n = 1'b1;
        tick();

        // ---- Single char: 0x41 at row 1, col 3; driver busy 5 cycles
        set_cmd(1'b1, 2'd0, 8'h41, 2'd1, 4'd3, 2'd0);
        tick();
        cmd_valid = 1'b0;
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_no_strobe_lat0", 32'(showchar), 32'd0);
        tick();
        check("single_no_strobe_lat1", 32'(showchar), 32'd0);
        check("single_count_popped", 32'(count), 32'd0);
        tick();
        check("single_showchar", 32'(showchar), 32'd1);
        check("single_showbmp", 32'(showbmp), 32'd0);
        check("single_clear", 32'(clear), 32'd0);
        check("single_charval", 32'(charval), 32'h41);
        check("single_row", 32'(char_row), 32'd1);
        check("single_col", 32'(char_col), 32'd3);
        drv_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("single_strobe_one_cycle", 32'(showchar), 32'd0);
            check("single_charval_hold", 32'(charval), 32'h41);
        end
        drv_ready = 1'b1;
        run_driver(15, 5);
        check("single_no_second_strobe", 32'(log_kind.size()), 32'd0);
        check("single_count_final", 32'(count), 32'd0);

        // ---- Reserved drop, fill to full, overflow (table driven)
        foreach (vecs[k]) begin
            set_cmd(vecs[k].valid, vecs[k].typ, vecs[k].ch, vecs[k].row, vecs[k].col, vecs[k].bm);
            drv_ready = vecs[k].drv;
            tick();
            check($sformatf("fill%0d_count", k), 32'(count), 32'(vecs[k].exp_count));
            check($sformatf("fill%0d_ready", k), 32'(cmd_ready), 32'(vecs[k].exp_ready));
            check($sformatf("fill%0d_overflow", k), 32'(overflow), 32'(vecs[k].exp_ovf));
            check($sformatf("fill%0d_nostrobe", k), 32'({showchar, showbmp, clear}), 32'd0);
        end
        cmd_valid = 1'b0;

        // ---- Release driver: 8 strobes in push order
        drv_ready = 1'b1;
        run_driver(80, 2);
        check("drain_n_strobes", 32'(log_kind.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < log_kind.size()) begin
                check($sformatf("drain%0d_kind", k), 32'(log_kind[k]), 32'd0);
                check($sformatf("drain%0d_charval", k), 32'(log_ch[k]), 32'h50 + 32'(k));
                check($sformatf("drain%0d_row", k), 32'(log_row[k]), 32'(k % 4));
                check($sformatf("drain%0d_col", k), 32'(log_col[k]), 32'(k));
            end
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_overflow_sticky", 32'(overflow), 32'd1);

        // ---- Mixed types: clear, bmp=2, char 0x30
        drv_ready = 1'b0;
        push(2'd2, 8'h00, 2'd0, 4'd0, 2'd0);
        push(2'd1, 8'h00, 2'd0, 4'd0, 2'd2);
        push(2'd0, 8'h30, 2'd2, 4'd5, 2'd0);
        check("mixed_count", 32'(count), 32'd3);
        drv_ready = 1'b1;
        run_driver(40, 2);
        check("mixed_n_strobes", 32'(log_kind.size()), 32'd3);
        if (log_kind.size() == 3) begin
            check("mixed0_kind_clear", 32'(log_kind[0]), 32'd2);
            check("mixed1_kind_bmp", 32'(log_kind[1]), 32'd1);
            check("mixed1_bmp", 32'(log_bmp[1]), 32'd2);
            check("mixed2_kind_char", 32'(log_kind[2]), 32'd0);
            check("mixed2_charval", 32'(log_ch[2]), 32'h30);
            check("mixed2_col", 32'(log_col[2]), 32'd5);
        end

        // ---- Timeout: driver never goes busy
        drv_ready = 1'b0;
        push(2'd0, 8'h11, 2'd0, 4'd1, 2'd0);
        push(2'd0, 8'h22, 2'd0, 4'd2, 2'd0);
        drv_ready = 1'b1;
        run_driver(60, 0);
        check("timeout_n_strobes", 32'(log_kind.size()), 32'd2);
        if (log_kind.size() == 2) begin
            check("timeout_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'(ACK_TIMEOUT + 2));
            check("timeout_second_charval", 32'(log_ch[1]), 32'h22);
        end

        // ---- Simultaneous push and pop at count=1
        drv_ready = 1'b0;
        push(2'd0, 8'h61, 2'd1, 4'd1, 2'd0);
        check("simul_count_pre", 32'(count), 32'd1);
        set_cmd(1'b1, 2'd0, 8'h62, 2'd2, 4'd2, 2'd0);
        drv_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("simul_count_same", 32'(count), 32'd1);
        run_driver(30, 2);
        check("simul_n_strobes", 32'(log_kind.size()), 32'd2);
        if (log_kind.size() == 2) begin
            check("simul_first", 32'(log_ch[0]), 32'h61);
            check("simul_second", 32'(log_ch[1]), 32'h62);
        end
        check("simul_count_final", 32'(count), 32'd0);

        // ---- Reset in WAIT_DONE with 3 entries queued
        drv_ready = 1'b0;
        push(2'd0, 8'h71, 2'd3, 4'd9, 2'd1);
        push(2'd0, 8'h72, 2'd0, 4'd0, 2'd0);
        push(2'd1, 8'h73, 2'd0, 4'd0, 2'd3);
        push(2'd2, 8'h74, 2'd0, 4'd0, 2'd0);
        check("rst_count_4", 32'(count), 32'd4);
        drv_ready = 1'b1;
        tick();
        tick();
        check("rst_pre_showchar", 32'(showchar), 32'd1);
        drv_ready = 1'b0;
        tick();
        check("rst_pre_count", 32'(count), 32'd3);
        check("rst_pre_charval", 32'(charval), 32'h71);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        set_cmd(1'b1, 2'd0, 8'h99, 2'd1, 4'd1, 2'd1);
        drv_ready = 1'b1;
        tick();
        tick();
        check("rst_no_accept_in_reset", 32'(count), 32'd0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        run_driver(20, 2);
        check("rst_no_strobe_after", 32'(log_kind.size()), 32'd0);
        check("rst_count_after", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_cmd_queue.md
OLED_CMD_QUEUE -- requirements
Module: oled_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-002 Parameter ACK_TIMEOUT, default 16, cycles to wait for the driver to drop ready after a command pulse.
REQ-003 clk  input  1  system clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  producer (game) offers a command this cycle.
REQ-006 cmd_type  input  2  command type: 0=char, 1=bmp, 2=clear, 3=reserved.
REQ-007 cmd_charval  input  8  character code.
REQ-008 cmd_row  input  2  character row.
REQ-009 cmd_col  input  4  character column.
REQ-010 cmd_bmp  input  2  bitmap select.
REQ-011 cmd_ready  output  1  queue can accept a command; high when the queue is not full.
REQ-012 drv_ready  input  1  oledDriver ready; high means the driver is idle.
REQ-013 showchar, showbmp, clear  output  1 each  one-cycle command strobes to the driver.
REQ-014 charval[7:0], char_row[1:0], char_col[3:0], bmp[1:0]  output  command operands to the driver.
REQ-015 count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-016 overflow  output  1  sticky flag; set when cmd_valid is high while cmd_ready is low.

Function
REQ-017 A command is accepted on any clock edge where cmd_valid and cmd_ready are both high.
- The entry stores type, charval, row, col and bmp in FIFO order.
REQ-018 A command with cmd_type=3 that meets REQ-017 is dropped: it is not stored and count does not change.
REQ-019 Offered commands with cmd_ready low are dropped and set overflow; overflow clears only on reset.
REQ-020 The state machine has four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE -> ISSUE when the FIFO is not empty and drv_ready=1.
- On this transition, the head entry is popped into the operand registers (charval, char_row, char_col, bmp).
REQ-022 In ISSUE, exactly one strobe is high for one cycle, chosen by the stored type: 0->showchar, 1->showbmp, 2->clear.
- The next state is WAIT_BUSY.
REQ-023 WAIT_BUSY -> WAIT_DONE when drv_ready=0.
- WAIT_BUSY -> IDLE after ACK_TIMEOUT cycles with drv_ready still high (command treated as complete).
REQ-024 WAIT_DONE -> IDLE when drv_ready=1.
REQ-025 Operand outputs hold their values from the ISSUE state until the next pop; they do not change while the driver is busy.
REQ-026 Minimum spacing between strobes is 4 cycles: ISSUE, WAIT_BUSY with at least 1 cycle busy, WAIT_DONE, IDLE.
REQ-027 If a push and a pop happen in the same cycle, count is unchanged; a push into a full queue in the same cycle as a pop is still rejected, because cmd_ready is computed from the registered count.
REQ-028 A push into an empty queue is visible to IDLE on the next cycle; latency from accept to strobe is at least 2 cycles.
REQ-029 Read and write pointers wrap modulo DEPTH.
- count = write_ptr - read_ptr, using one extra pointer bit.
REQ-030 All strobe outputs are registered; at most one of them is high in any cycle.

Reset
REQ-031 While rst_n=0, the block is forced to this state, immediately and independent of clk:
- state=IDLE, pointers=0, count=0, overflow=0
- showchar=showbmp=clear=0
- charval=0, char_row=0, char_col=0, bmp=0
- cmd_ready=1
REQ-032 A reset in any state, including during a strobe, discards all queued entries; no strobe is issued after reset until a new command is accepted.
REQ-033 Release of rst_n takes effect on the first clock edge after deassertion; no command is accepted while rst_n=0.

Verification
REQ-034 Single char: push type0, charval=0x41, row=1, col=3 with drv_ready=1, and the driver drops ready for 5 cycles after the strobe.
- Required: a showchar pulse 2 cycles after accept, with charval=0x41, char_row=1, char_col=3.
- Required: count returns to 0 and there is no second strobe.
REQ-035 Fill and overflow: with drv_ready held 0, push 9 commands.
- Required: count=8 and cmd_ready=0 after the 8th push.
- Required: the 9th push is dropped and overflow=1.
- Then release drv_ready: 8 strobes occur in push order.
REQ-036 Mixed types: push clear, bmp=2, char 0x30.
- Required: strobes in the order clear, showbmp (bmp=2), showchar (charval=0x30), never two strobes in one cycle.
REQ-037 Timeout: the driver keeps drv_ready=1 and never goes busy.
- Required: the next strobe follows the previous one by ACK_TIMEOUT+2 cycles.
REQ-038 Reset mid-operation: assert rst_n=0 in WAIT_DONE with 3 entries queued.
- Required: all outputs reach their reset values with no clock edge, count=0, and no strobe is issued after release.
REQ-039 Simultaneous push and pop at count=1.
- Required: count stays 1 and the pushed entry is the next one issued.
